// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH : default operand/result width
//   op_e      : operation encoding presented on the op port
//   state_e   : sequencing states of mul_div_unit
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : upper accumulator (partial product high / partial remainder)
//   mq       : multiplier being consumed LSB-first / dividend being consumed
//              MSB-first with quotient bits entering at the LSB
//   operand  : multiplicand or divisor magnitude
//   acc_next, mq_next : register values after this iteration
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (diff[WIDTH]) begin
        acc_next = shifted[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = diff[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Carry of the add becomes the new MSB of the shifted product.
      acc_next = sum[WIDTH:1];
      mq_next  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and divide unit, WIDTH+3 cycles per op.
//   clk, rst (async, active-low), start, op, a, b, flush : control/operands
//   busy        : state is not IDLE
//   done        : one-cycle pulse, hi/lo/div_by_zero/op_err valid with it
//   hi, lo      : product high/low or remainder/quotient, held between ops
//   div_by_zero : divide with b == 0
//   op_err      : divide requested while divide hardware is absent
// Build option: define MUL_DIV_UNIT_DIV_EN to include the divide datapath.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             op_err
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             state;
  op_e                op_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   operand, acc, mq;
  logic               neg_res, pend_dbz, pend_err;
  logic [WIDTH-1:0]   acc_next, mq_next;
  logic               step_div;
  logic               in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH-1:0]   a_q;
  logic               b_zero, neg_rem;
`endif

  assign busy = (state != IDLE);

`ifdef MUL_DIV_UNIT_DIV_EN
  assign step_div = op_is_div(op_q);
`else
  assign step_div = 1'b0;
`endif

  always_comb begin
    in_signed = ~op[0];
    mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;
    prod_fix  = neg_res ? -{acc, mq} : {acc, mq};
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (step_div),
    .acc      (acc),
    .mq       (mq),
    .operand  (operand),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  // done/flags are registered on the edge leaving DONE, so the pulse lands
  // WIDTH+2 edges after the accepting edge while hi/lo update entering DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= OP_MULT;
      count       <= '0;
      operand     <= '0;
      acc         <= '0;
      mq          <= '0;
      neg_res     <= 1'b0;
      pend_dbz    <= 1'b0;
      pend_err    <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      a_q         <= '0;
      b_zero      <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            op_q    <= op_e'(op);
            acc     <= '0;
            mq      <= mag_a;
            operand <= mag_b;
            neg_res <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            count   <= '0;
            state   <= CALC;
`ifdef MUL_DIV_UNIT_DIV_EN
            a_q     <= a;
            b_zero  <= (b == '0);
            neg_rem <= in_signed & a[WIDTH-1];
`endif
          end
          CALC: begin
            acc   <= acc_next;
            mq    <= mq_next;
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            state    <= DONE;
            pend_dbz <= 1'b0;
            pend_err <= 1'b0;
            if (!op_is_div(op_q)) begin
              {hi, lo} <= prod_fix;
            end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
              if (b_zero) begin
                hi       <= a_q;
                lo       <= '1;
                pend_dbz <= 1'b1;
              end else begin
                hi <= neg_rem ? -acc : acc;
                lo <= neg_res ? -mq : mq;
              end
`else
              pend_err <= 1'b1;
`endif
            end
          end
          DONE: begin
            state       <= IDLE;
            done        <= 1'b1;
            div_by_zero <= pend_dbz;
            op_err      <= pend_err;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32) with an arithmetic reference
// model. Honours MUL_DIV_UNIT_DIV_EN the same way as the design.
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero, op_err;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on sign-extended / zero-extended values.
  function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] x, y,
                                    input logic [W-1:0] ph, pl,
                                    output logic [W-1:0] rh, rl,
                                    output logic rz, re);
    longint sx, sy, q, r;
    logic [2*W-1:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = ph; rl = pl; rz = 1'b0; re = 1'b0;
    if (o == 2'b00) begin
      p = sx * sy; rh = p[2*W-1:W]; rl = p[W-1:0];
    end else if (o == 2'b01) begin
      p = {32'b0, x} * {32'b0, y}; rh = p[2*W-1:W]; rl = p[W-1:0];
    end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
      if (y == 0) begin
        rl = '1; rh = x; rz = 1'b1;
      end else if (o == 2'b11) begin
        rl = x / y; rh = x % y;
      end else begin
        q = sx / sy; r = sx % sy; rl = q[W-1:0]; rh = r[W-1:0];
      end
`else
      re = 1'b1;
`endif
    end
  endfunction

  // Presents one request, scrambles the operands after acceptance and counts
  // edges until done is seen (bounded).
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, op_err} !== 4'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b err=%b hi=%h lo=%h required all 0",
               busy, done, div_by_zero, op_err, hi, lo);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_directed;
    int lat;
    issue(2'b00, 32'hFFFFFFFD, 32'd5, lat);
    checks++;
    if (lat !== LAT || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_neg: lat=%0d hi=%h lo=%h required lat=%0d hi=FFFFFFFF lo=FFFFFFF1",
               lat, hi, lo, LAT);
    end
    exp_hi = hi; exp_lo = lo;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_cycle: done=%b required 0", done);
    end
`ifdef MUL_DIV_UNIT_DIV_EN
    issue(2'b10, 32'hFFFFFFF9, 32'd2, lat);
    checks++;
    if (lat !== LAT || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_neg: lat=%0d hi=%h lo=%h dbz=%b required hi=FFFFFFFF lo=FFFFFFFD dbz=0",
               lat, hi, lo, div_by_zero);
    end
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== LAT || lo !== 32'h80000000 || hi !== '0 || div_by_zero !== 1'b0 || op_err !== 1'b0) begin
      errors++;
      $display("FAIL div_overflow: hi=%h lo=%h dbz=%b err=%b required hi=0 lo=80000000 flags 0",
               hi, lo, div_by_zero, op_err);
    end
    exp_hi = '0; exp_lo = 32'h80000000;
`endif
  endtask

  task automatic test_div_by_zero;
    int lat;
    issue(2'b11, 32'h10, 32'h0, lat);
`ifdef MUL_DIV_UNIT_DIV_EN
    checks++;
    if (lat !== LAT || lo !== 32'hFFFFFFFF || hi !== 32'h10 || div_by_zero !== 1'b1 || op_err !== 1'b0) begin
      errors++;
      $display("FAIL divu_zero: lat=%0d hi=%h lo=%h dbz=%b err=%b required hi=10 lo=FFFFFFFF dbz=1 err=0",
               lat, hi, lo, div_by_zero, op_err);
    end
    exp_hi = 32'h10; exp_lo = 32'hFFFFFFFF;
`else
    checks++;
    if (lat !== LAT || op_err !== 1'b1 || div_by_zero !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL divu_absent: lat=%0d err=%b dbz=%b hi=%h lo=%h required err=1 dbz=0 hi=%h lo=%h",
               lat, op_err, div_by_zero, hi, lo, exp_hi, exp_lo);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== LAT || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_max: lat=%0d hi=%h lo=%h required hi=FFFFFFFE lo=00000001", lat, hi, lo);
    end
    exp_hi = 32'hFFFFFFFE; exp_lo = 32'h1;
    // issue() drives start in the done cycle, i.e. straight after DONE.
    issue(2'b11, 32'd7, 32'd2, lat);
`ifdef MUL_DIV_UNIT_DIV_EN
    checks++;
    if (lat !== LAT || lo !== 32'd3 || hi !== 32'd1) begin
      errors++;
      $display("FAIL b2b_divu: lat=%0d hi=%h lo=%h required lat=%0d hi=1 lo=3", lat, hi, lo, LAT);
    end
    exp_hi = 32'd1; exp_lo = 32'd3;
`else
    checks++;
    if (lat !== LAT || op_err !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL b2b_divu_absent: lat=%0d err=%b hi=%h lo=%h required err=1 hi=%h lo=%h",
               lat, op_err, hi, lo, exp_hi, exp_lo);
    end
`endif
  endtask

  task automatic test_random;
    logic [W-1:0] x, y, eh, el;
    logic [1:0]   o;
    logic         ez, ee;
    int           lat;
    logic [W-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      ref_model(o, x, y, exp_hi, exp_lo, eh, el, ez, ee);
      issue(o, x, y, lat);
      checks++;
      if (lat !== LAT || hi !== eh || lo !== el || div_by_zero !== ez || op_err !== ee) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dbz=%b err=%b required lat=%0d hi=%h lo=%h dbz=%b err=%b",
                 i, o, x, y, lat, hi, lo, div_by_zero, op_err, LAT, eh, el, ez, ee);
      end
      exp_hi = eh; exp_lo = el;
    end
  endtask

  task automatic test_busy_start;
    logic [W-1:0] eh, el;
    logic         ez, ee;
    int           lat;
    bit           extra;
    ref_model(2'b01, 32'd1000, 32'd77, exp_hi, exp_lo, eh, el, ez, ee);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(negedge clk) start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== LAT || hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL busy_start_result: lat=%0d hi=%h lo=%h required lat=%0d hi=%h lo=%h",
               lat, hi, lo, LAT, eh, el);
    end
    exp_hi = eh; exp_lo = el;
    extra = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_queued: activity=%b required 0", extra);
    end
  endtask

  task automatic test_flush;
    bit saw;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: busy=%b required 0", busy);
    end
    flush = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL flush_hold: done_seen=%b hi=%h lo=%h required done_seen=0 hi=%h lo=%h",
               saw, hi, lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, op_err} !== 4'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dbz=%b err=%b hi=%h lo=%h required all 0",
               busy, done, div_by_zero, op_err, hi, lo);
    end
    exp_hi = '0; exp_lo = '0;
    @(negedge clk) rst = 1'b1;
    issue(2'b00, 32'd3, 32'd4, lat);
    checks++;
    if (lat !== LAT || lo !== 32'd12 || hi !== '0) begin
      errors++;
      $display("FAIL reset_then_mult: lat=%0d hi=%h lo=%h required lat=%0d hi=0 lo=12",
               lat, hi, lo, LAT);
    end
    exp_hi = '0; exp_lo = 32'd12;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_by_zero;
    test_back_to_back;
    test_random;
    test_busy_start;
    test_flush;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; legal values are even numbers from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: a is multiplicand or dividend; b is multiplier or divisor.
REQ-007 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-008 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle result-valid pulse.
REQ-010 SHALL have ports hi and lo, output, WIDTH bits each: upper product / remainder, and lower product / quotient.
REQ-011 SHALL have port div_by_zero, output, 1 bit: valid while done is high.
REQ-012 SHALL have port op_err, output, 1 bit: valid while done is high.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE: IDLE goes to CALC on start; CALC stays for exactly WIDTH cycles; then FIX for 1 cycle; then DONE for 1 cycle; then IDLE.
REQ-014 SHALL latch op, a and b on the edge that accepts start; later operand changes SHALL have no effect.
REQ-015 SHALL assert done in the cycle following edge WIDTH+2, counted from the accept edge; latency is fixed and independent of operand values.
REQ-016 SHALL ignore start while busy is high: no queuing, no error.
REQ-017 SHALL use iterative shift-add for multiply (one bit per CALC cycle) and restoring division (one quotient bit per CALC cycle), on operand magnitudes.
REQ-018 SHALL, in FIX, negate results for signed ops: product negated when the operand signs differ; quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-019 SHALL, for DIV/DIVU with b==0, produce lo=all ones, hi=a and div_by_zero=1, with the same latency.
REQ-020 SHALL, for DIV with a=most-negative value and b=-1, produce lo=most-negative value and hi=0, with no flag.
REQ-021 SHALL update hi and lo only on entry to DONE; they SHALL hold their values until the next DONE.
REQ-022 SHALL, when flush is high, enter IDLE on the next edge from any state, with no done pulse and hi/lo unchanged.
REQ-023 SHALL give flush priority over start when both are high in IDLE; start is dropped.
REQ-024 SHALL accept a new start in the cycle immediately after DONE, giving back-to-back throughput of one result per WIDTH+3 cycles.

Reset
REQ-025 SHALL, on rst low, immediately set state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, op_err=0, and the iteration counter to 0.
REQ-026 SHALL, on reset asserted mid-operation, abandon the operation, produce no done pulse after release, and become ready for start in the first cycle after release.

Configuration
REQ-027 SHALL support divide hardware only when macro MUL_DIV_UNIT_DIV_EN is defined.
REQ-028 SHALL, with MUL_DIV_UNIT_DIV_EN defined, behave as specified for all four ops.
REQ-029 SHALL, without MUL_DIV_UNIT_DIV_EN, handle DIV/DIVU with the same latency, leave hi/lo unchanged, pulse op_err=1 with done, and hold div_by_zero=0; the divide datapath is not synthesized.

Structure
REQ-030 SHALL place the op encoding enum, the state enum and the default WIDTH constant in shared package mdu_pkg.
REQ-031 SHALL contain one sub-module, mdu_step: a combinational single iteration (conditional add for multiply, trial subtract for divide) parametrised by WIDTH.

Verification
REQ-032 SHALL verify MULT, WIDTH=32, a=0xFFFFFFFD, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, with done exactly 34 edges after accept.
REQ-033 SHALL verify MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then back-to-back DIVU a=7, b=2 -> lo=3, hi=1.
REQ-034 SHALL verify DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 SHALL verify DIVU a=0x10, b=0 -> lo=0xFFFFFFFF, hi=0x10, div_by_zero=1; and, without MUL_DIV_UNIT_DIV_EN, the same stimulus -> op_err=1 with hi/lo unchanged.
REQ-036 SHALL verify flush at CALC cycle 10 -> busy=0 next cycle, no done, hi/lo hold the prior result; and start pulsed while busy -> ignored.
REQ-037 SHALL verify rst low at CALC cycle 5 -> all outputs 0 immediately; after release, a MULT 3x4 -> lo=12, hi=0 with nominal latency.
